// File: rtl/array_dump_b_pkg.sv
// Shared types and ASCII constants for the binary-text array dumper.
package array_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        BITS,
        EOL,
        DONE
    } state_e;

    localparam logic [7:0] CHR_0  = 8'h30;
    localparam logic [7:0] CHR_1  = 8'h31;
    localparam logic [7:0] CHR_LF = 8'h0A;

    function automatic logic [7:0] bit_chr(input logic b);
        return b ? CHR_1 : CHR_0;
    endfunction

endpackage

// File: rtl/array_dump_b_if.sv
// Memory read port plus outgoing byte stream of the array dumper.
interface array_dump_b_if #(
    parameter int WA = 8,
    parameter int WB = 8
);
    localparam int AW = (WA > 1) ? $clog2(WA) : 1;

    logic          mem_ren;
    logic [AW-1:0] mem_adr;
    logic [WB-1:0] mem_rdt;
    logic          tx_vld;
    logic          tx_rdy;
    logic [7:0]    tx_dat;

    modport master (
        output mem_ren, mem_adr, tx_vld, tx_dat,
        input  mem_rdt, tx_rdy
    );

    modport slave (
        input  mem_ren, mem_adr, tx_vld, tx_dat,
        output mem_rdt, tx_rdy
    );

endinterface

// File: rtl/array_dump_b.sv
// Walks a sync-read memory and streams each word as '0'/'1' text, MSB first,
// one word per line, in the binary memory-image text format.
module array_dump_b
    import array_dump_pkg::*;
#(
    parameter  int WA = 8,
    parameter  int WB = 8,
    localparam int AW = (WA > 1) ? $clog2(WA) : 1,
    localparam int CW = (WB > 1) ? $clog2(WB) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW:0]     len,
    output logic            busy,
    output logic            done,
    array_dump_b_if.master  bus
);

    state_e        state_q;
    logic [AW:0]   n_q;
    logic [AW:0]   adr_q;
    logic [WB-1:0] sh_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          ren_q;
    logic [AW-1:0] madr_q;
    logic          vld_q;
    logic [7:0]    dat_q;

    logic [AW:0]   n_d;
    logic [AW:0]   adr_d;
    logic [WB-1:0] sh_d;
    logic          hs;

    // Address counter is one bit wider than mem_adr so n==WA compares cleanly.
    assign n_d   = (len > (AW+1)'(WA)) ? (AW+1)'(WA) : len;
    assign adr_d = adr_q + (AW+1)'(1);
    assign sh_d  = sh_q << 1;
    assign hs    = vld_q && bus.tx_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            adr_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            madr_q  <= '0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q    <= n_d;
                        adr_q  <= '0;
                        madr_q <= '0;
                        if (n_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            ren_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    ren_q   <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    sh_q    <= bus.mem_rdt;
                    cnt_q   <= CW'(WB-1);
                    vld_q   <= 1'b1;
                    dat_q   <= bit_chr(bus.mem_rdt[WB-1]);
                    state_q <= BITS;
                end
                BITS: begin
                    if (hs) begin
                        if (cnt_q == '0) begin
                            dat_q   <= CHR_LF;
                            state_q <= EOL;
                        end else begin
                            sh_q  <= sh_d;
                            cnt_q <= cnt_q - CW'(1);
                            dat_q <= bit_chr(sh_d[WB-1]);
                        end
                    end
                end
                EOL: begin
                    if (hs) begin
                        vld_q <= 1'b0;
                        dat_q <= '0;
                        adr_q <= adr_d;
                        if (adr_d == n_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= READ;
                            ren_q   <= 1'b1;
                            madr_q  <= adr_d[AW-1:0];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign bus.mem_ren = ren_q;
    assign bus.mem_adr = madr_q;
    assign bus.tx_vld  = vld_q;
    assign bus.tx_dat  = dat_q;

endmodule

// File: tb/tb_array_dump_b.sv
// Table-driven bench for array_dump_b: behavioural memory, byte sink,
// binary-text decode of the captured stream.
module tb_array_dump_b;
    import array_dump_pkg::*;

    localparam int WA = 8;
    localparam int WB = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;

    array_dump_b_if #(.WA(WA), .WB(WB)) bus ();

    array_dump_b #(.WA(WA), .WB(WB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WB-1:0] mem [WA];
    always @(posedge clk) if (bus.mem_ren) bus.mem_rdt <= mem[bus.mem_adr];

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] rx [0:1023];
    int nbytes, done_cyc, first_vld, busy_cyc, ren_cnt;
    int bad_ren, stall_bad, rst_hit, rst_vld, rst_busy, rst_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_dump(input int l, input bit rnd, input bit restart, input int rst_byte);
        int cyc;
        int nexp;
        bit prev_stall;
        logic [7:0] prev_dat;
        logic rdy;
        nexp = (l > WA) ? WA : l;
        nbytes = 0; done_cyc = -1; first_vld = -1; busy_cyc = 0; ren_cnt = 0;
        bad_ren = 0; stall_bad = 0; rst_hit = 0; rst_vld = 0; rst_busy = 0; rst_done = 0;
        prev_stall = 0; prev_dat = '0;
        @(negedge clk);
        start = 1'b1; len = l[AW:0]; bus.tx_rdy = 1'b0;
        @(posedge clk);
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // start pulse while busy must be ignored
            start = restart && (cyc == 5);
            if (restart && cyc == 5) len = 4'd1;
            if (busy) busy_cyc++;
            if (bus.mem_ren) begin
                ren_cnt++;
                if (int'(bus.mem_adr) >= nexp) bad_ren = 1;
            end
            if (bus.tx_vld && first_vld < 0) first_vld = cyc;
            if (prev_stall && (!bus.tx_vld || bus.tx_dat !== prev_dat)) stall_bad = 1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (rst_byte >= 0 && bus.tx_vld && nbytes == rst_byte) begin
                rst = 1'b1; bus.tx_rdy = 1'b0;
                @(negedge clk);
                rst_vld = bus.tx_vld; rst_busy = busy; rst_done = done; rst_hit = 1;
                rst = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (done) rst_done = 1;
                    if (bus.tx_vld) rst_vld = 1;
                end
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.tx_rdy = rdy;
            if (bus.tx_vld && rdy) begin
                if (nbytes < 1024) rx[nbytes] = bus.tx_dat;
                nbytes++;
            end
            prev_stall = bus.tx_vld && !rdy;
            prev_dat = bus.tx_dat;
        end
        start = 1'b0; bus.tx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_stream(input string name, input int nw);
        int bad;
        int k;
        logic [7:0] e;
        logic [WB-1:0] got;
        check({name, " bytes"}, nbytes, nw * (WB + 1));
        bad = 0; k = 0;
        for (int w = 0; w < nw; w++) begin
            for (int b = WB - 1; b >= 0; b--) begin
                e = mem[w][b] ? 8'h31 : 8'h30;
                if (k >= nbytes || rx[k] !== e) bad++;
                k++;
            end
            if (k >= nbytes || rx[k] !== 8'h0A) bad++;
            k++;
        end
        check({name, " content"}, bad, 0);
        // Decode the text as a binary memory image and compare with the array
        bad = 0;
        for (int w = 0; w < nw; w++) begin
            got = 'x;
            for (int i = 0; i < WB; i++) begin
                k = w * (WB + 1) + i;
                if (k < nbytes && rx[k] == 8'h31) got = {got[WB-2:0], 1'b1};
                else if (k < nbytes && rx[k] == 8'h30) got = {got[WB-2:0], 1'b0};
                else got = {got[WB-2:0], 1'bx};
            end
            if (got !== mem[w]) bad++;
        end
        check({name, " readback"}, bad, 0);
    endtask

    typedef struct {
        int len;
        bit rnd;
        bit restart;
        int nw;
        int done_at;
        int first_at;
    } vec_t;

    vec_t vt [7];

    task automatic check_line(input string name, input int base, input logic [71:0] exp);
        logic [71:0] got;
        for (int i = 0; i < 9; i++) got[71 - 8*i -: 8] = rx[base + i];
        check(name, (got == exp) ? 1 : 0, 1);
    endtask

    initial begin
        for (int a = 0; a < WA; a++) mem[a] = WB'(a);
        rst = 1'b1; start = 1'b0; len = '0; bus.tx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy",    busy,        0);
        check("rst done",    done,        0);
        check("rst mem_ren", bus.mem_ren, 0);
        check("rst mem_adr", bus.mem_adr, 0);
        check("rst tx_vld",  bus.tx_vld,  0);
        check("rst tx_dat",  bus.tx_dat,  0);
        rst = 1'b0;

        vt[0] = '{8, 1'b0, 1'b0, 8, 89, 3};
        vt[1] = '{7, 1'b0, 1'b0, 7, 78, 3};
        vt[2] = '{0, 1'b0, 1'b0, 0,  1, -1};
        vt[3] = '{9, 1'b0, 1'b0, 8, 89, 3};
        vt[4] = '{8, 1'b1, 1'b0, 8, -1, 3};
        vt[5] = '{8, 1'b0, 1'b1, 8, 89, 3};
        vt[6] = '{1, 1'b0, 1'b0, 1, 12, 3};

        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("v%0d", v);
            run_dump(vt[v].len, vt[v].rnd, vt[v].restart, -1);
            check_stream(nm, vt[v].nw);
            if (vt[v].done_at >= 0) begin
                check({nm, " done cycle"}, done_cyc, vt[v].done_at);
                check({nm, " busy cycles"}, busy_cyc, (vt[v].nw == 0) ? 0 : vt[v].done_at - 1);
            end else begin
                check({nm, " done seen"}, (done_cyc > 0) ? 1 : 0, 1);
                check({nm, " busy cycles"}, busy_cyc, done_cyc - 1);
            end
            check({nm, " first vld"}, first_vld, vt[v].first_at);
            check({nm, " ren count"}, ren_cnt, vt[v].nw);
            check({nm, " ren range"}, bad_ren, 0);
            check({nm, " stall hold"}, stall_bad, 0);
            if (v == 0) begin
                check_line("v0 first line", 0, "00000000\n");
                check_line("v0 last line", 63, "00000111\n");
            end
            if (v == 1) check_line("v1 last line", 54, "00000110\n");
        end

        // Reset during the third character of word 2
        run_dump(8, 1'b0, 1'b0, 2 * (WB + 1) + 2);
        check("mid rst hit",    rst_hit,  1);
        check("mid rst tx_vld", rst_vld,  0);
        check("mid rst busy",   rst_busy, 0);
        check("mid rst done",   rst_done, 0);

        run_dump(8, 1'b0, 1'b0, -1);
        check_stream("post rst", 8);
        check("post rst done cycle", done_cyc, 89);
        check("post rst first vld", first_vld, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
